// File: rtl/neuron_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_mac_accum
//  Description : Serial multiply-accumulate front end of the digital neuron.
//                Loads a signed bias on start, accepts N_INPUTS signed (x, w)
//                pairs over a valid/ready handshake, adds each full-precision
//                product (sign-extended) to the accumulator and presents the
//                ACC_W-bit weighted sum with a one-cycle sum_valid pulse.
//  Ports       : clk, rst_n (async active-low)
//                start, bias       - begin evaluation, bias sampled with start
//                in_valid/in_ready - x/w pair handshake (ready only in ACC)
//                x, w              - signed activation / weight
//                sum_out           - registered signed weighted sum
//                sum_valid         - one-cycle pulse, sum_out final
//                busy              - evaluation in progress
//  Config      : MAC_SAT_EN defined   -> every add saturates to ACC_W range
//                MAC_SAT_EN undefined -> adds wrap modulo 2^ACC_W
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_mac_accum #(
    parameter int IN_W     = 8,
    parameter int W_W      = 8,
    parameter int ACC_W    = 21,
    parameter int N_INPUTS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] bias,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [W_W-1:0]   w,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    sum_valid,
    output logic                    busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int PRD_W = IN_W + W_W;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(N_INPUTS - 1);

    logic [1:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_count;
    logic signed [ACC_W-1:0] r_sum_out;

    logic signed [PRD_W-1:0] w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_accept;

    assign w_prod     = x * w;
    assign w_prod_ext = ACC_W'(w_prod);     // signed cast sign-extends
    assign w_accept   = in_valid && (r_state == c_ACC) && !start;

`ifdef MAC_SAT_EN
    // One extra bit exposes overflow; the two top bits disagree on overflow
    // and the very top bit gives the true sign to clamp toward.
    logic signed [ACC_W:0] w_sum_wide;

    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};

    always_comb begin
        w_sum = w_sum_wide[ACC_W-1:0];
        if (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]) begin
            w_sum = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_sum = r_acc + w_prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_sum_out <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_ACC;
                        r_acc   <= bias;
                        r_count <= '0;
                    end
                end
                c_ACC: begin
                    if (start) begin
                        // Restart: any pair presented this cycle is dropped.
                        r_acc   <= bias;
                        r_count <= '0;
                    end else if (w_accept) begin
                        r_acc   <= w_sum;
                        r_count <= r_count + 1'b1;
                        if (r_count == c_LAST) begin
                            // The final sum is captured on entry to DONE so
                            // that sum_out is already final while sum_valid
                            // is high during the DONE cycle.
                            r_sum_out <= w_sum;
                            r_state   <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    if (start) begin
                        r_state <= c_ACC;
                        r_acc   <= bias;
                        r_count <= '0;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_ACC);
    assign busy      = (r_state == c_ACC);
    assign sum_valid = (r_state == c_DONE);
    assign sum_out   = r_sum_out;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_mac_accum
//  Description : Self-checking bench for neuron_mac_accum. Expected sums are
//                computed from bias plus products with plain integer maths
//                and queued; a monitor pops and compares on sum_valid.
//                Build with MAC_SAT_EN to check the saturating variant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_mac_accum;

    localparam int IN_W  = 8;
    localparam int W_W   = 8;
    localparam int ACC_W = 21;
    localparam int N     = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic signed [ACC_W-1:0] bias;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  x;
    logic signed [W_W-1:0]   w;
    logic signed [ACC_W-1:0] sum_out;
    logic                    sum_valid;
    logic                    busy;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint exp_q[$];
    int     tx[N];
    int     tw[N];

    neuron_mac_accum #(
        .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .N_INPUTS(N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
        .sum_out(sum_out), .sum_valid(sum_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic: one add of an integer product to the running sum.
    function automatic longint model_add(input longint acc, input longint prod);
        longint v, m, lo, hi;
        v  = acc + prod;
        m  = longint'(1) << ACC_W;
        lo = -(m / 2);
        hi = (m / 2) - 1;
`ifdef MAC_SAT_EN
        if (v > hi) v = hi;
        if (v < lo) v = lo;
`else
        v = ((v % m) + m) % m;
        if (v > hi) v = v - m;
`endif
        return v;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && sum_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sum_valid: got sum_out %0d, expected no pulse at %0t",
                         sum_out, $time);
            end else begin
                check("sum_out", sum_out, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full evaluation from tx/tw; expected sum queued at issue time.
    task automatic run_eval(input longint b, input int gap_max, input bit valid_on_start);
        longint e;
        e = b;
        for (int i = 0; i < N; i++) e = model_add(e, longint'(tx[i] * tw[i]));
        exp_q.push_back(e);
        start    = 1'b1;
        bias     = ACC_W'(b);
        in_valid = valid_on_start;
        x        = 8'sd50;
        w        = 8'sd50;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                x        = IN_W'($urandom);
                tick();
                check("in_ready_gap", in_ready, 1);
                check("no_early_valid_gap", sum_valid, 0);
            end
            in_valid = 1'b1;
            x        = IN_W'(tx[i]);
            w        = W_W'(tw[i]);
            check("in_ready_acc", in_ready, 1);
            tick();
            if (i < N - 1) check("no_early_valid", sum_valid, 0);
            else           check("valid_latency", sum_valid, 1);
        end
        // Junk pair in DONE must be ignored.
        in_valid = 1'($urandom_range(0, 1));
        x        = IN_W'($urandom);
        w        = W_W'($urandom);
    endtask

    // Evaluation that is abandoned after npairs (restart or reset follows).
    task automatic partial(input longint b, input int npairs);
        start    = 1'b1;
        bias     = ACC_W'(b);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < npairs; i++) begin
            in_valid = 1'b1;
            x        = IN_W'(i + 3);
            w        = W_W'(i + 5);
            tick();
        end
    endtask

    task automatic set_pairs(input int x0, w0, x1, w1, x2, w2, x3, w3);
        tx[0] = x0; tw[0] = w0; tx[1] = x1; tw[1] = w1;
        tx[2] = x2; tw[2] = w2; tx[3] = x3; tw[3] = w3;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        longint b;
        rst_n    = 1'b0;
        start    = 1'b0;
        bias     = '0;
        in_valid = 1'b0;
        x        = '0;
        w        = '0;
        #2;
        check("rst_sum_out", sum_out, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // in_valid while IDLE is ignored.
        in_valid = 1'b1;
        x = 8'sd9; w = 8'sd9;
        tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);

        // 1: back-to-back.
        set_pairs(1, 10, 2, -1, 3, 2, 4, 5);
        run_eval(100, 0, 1'b0);
        idle(2);
        // 2: gapped.
        run_eval(100, 3, 1'b0);
        idle(2);
        // 3: overflow.
        set_pairs(127, 127, 0, 0, 0, 0, 0, 0);
        run_eval(1048000, 0, 1'b0);
        idle(1);
        // 4: negative products / sign extension.
        set_pairs(-128, -128, -128, 127, 1, -1, 0, 9);
        run_eval(-5, 1, 1'b0);
        idle(2);
        // 5: restart in ACC; the pair shown with the restart is dropped.
        partial(33, 2);
        check("busy_mid_acc", busy, 1);
        set_pairs(1, 1, 1, 1, 1, 1, 1, 1);
        run_eval(7, 0, 1'b1);
        idle(3);

        // 6: asynchronous reset mid-evaluation.
        partial(500, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum_out", sum_out, 0);
        check("async_rst_sum_valid", sum_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_busy", busy, 0);
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        repeat (N + 2) begin
            x = IN_W'($urandom);
            tick();
            check("post_rst_in_ready", in_ready, 0);
        end
        idle(1);

        // Randomised evaluations, including starts issued during DONE.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       b = (longint'(1) << (ACC_W - 1)) - 1 - $urandom_range(0, 20000);
                1:       b = -(longint'(1) << (ACC_W - 1)) + $urandom_range(0, 20000);
                default: b = longint'(ACC_W'($urandom)) - (longint'(1) << (ACC_W - 1));
            endcase
            for (int i = 0; i < N; i++) begin
                tx[i] = int'($urandom_range(0, 255)) - 128;
                tw[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_eval(b, 2, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(4);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
